rr_packet_arbiter: RTL
======================

Name: rr_packet_arbiter

Overview:
- Parametrised N-input round-robin arbiter for a router output port; successor to the fixed 4-input, 5-bit port arbiter.
- Grants one requester per cycle when the downstream port can accept.
- Optionally locks the grant to one requester for a whole multi-flit packet, until its tail flit.
- Rotates priority to the input after the winner once each packet completes.

Parameters:
- N_REQ, 4, number of requesting inputs (>=1).
- PLD_W, 5, width of each requester's payload (route/port vector) forwarded on grant.
- LOCK_EN, 1, 1 = hold grant until tail flit; 0 = re-arbitrate every flit.
- IDX_W, $clog2(N_REQ) (min 1), width of grant index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-input request.
- req_pld  in  N_REQ*PLD_W  payloads; input i occupies bits [i*PLD_W +: PLD_W].
- req_tail  in  N_REQ  flit on input i is the last flit of its packet.
- out_ready  in  1  downstream can accept this cycle (replaces legacy "empty").
- grant_vld  out  1  a transfer occurs this cycle.
- grant_oh  out  N_REQ  one-hot grant.
- grant_idx  out  IDX_W  binary index of the winner.
- grant_pld  out  PLD_W  payload of the winner; 0 when grant_vld=0.
- locked  out  1  packet lock held (registered state).

Behaviour:
- Grant outputs are combinational from the registered state (ptr, state, owner) and current inputs: zero-cycle latency, as in the legacy arbiter.
- While rst=1, all grant outputs are forced to 0.
- Reset values: ptr=0, state=IDLE, owner=0, locked=0.
- grant_vld=1 only if out_ready=1. A grant is a transfer; there is no separate accept.
- IDLE state:
  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping mod N_REQ.
  - No valid requests or out_ready=0: all grant outputs 0; ptr and state hold.
- On a grant in IDLE to winner w:
  - If req_tail[w]=1 or LOCK_EN=0: ptr <= (w+1) mod N_REQ; stay IDLE.
  - Otherwise: owner <= w; state <= LOCKED; ptr unchanged.
- LOCKED state:
  - Only the owner can be granted; all other requests are ignored.
  - Owner req_valid=0 or out_ready=0: grant outputs 0; stay LOCKED. Bubbles inside a packet are allowed.
  - Owner granted with req_tail=1: state <= IDLE; ptr <= (owner+1) mod N_REQ. Another input may win the very next cycle.
- Single-flit packets (tail on the first flit) never enter LOCKED.
- Wrap-around: a winner at N_REQ-1 sets ptr to 0.
- N_REQ=1: the single input is always the winner when valid; ptr stays 0.
- Reset mid-packet: lock is dropped and ptr returns to 0. A partial packet is the upstream's problem.
- Registered state has exactly two states, IDLE and LOCKED, plus a binary ptr and owner. Illegal state encodings recover to IDLE.
- grant_oh is always one-hot or zero, and always agrees with grant_idx.

Decomposition:
- Shared package (noc_arb_pkg):
  - State encoding constants ARB_IDLE / ARB_LOCKED.
  - clog2 helper function.
  - Default PLD_W = 5 shared with router port definitions.
- One sub-module: rr_prio_pick.
  - Combinational: req vector + ptr in; one-hot winner, index and any-valid flag out.
  - Implementation: rotate, priority-encode, rotate back.
  - Reused by the top in both states (in LOCKED, fed the owner-masked request).

Test Plan:
- Reset then all four inputs valid, tails=1, out_ready=1 for 8 cycles -> grant_idx 0,1,2,3,0,1,2,3; grant_pld equals each input's payload (e.g. 5'b00001, 5'b00010, 5'b00100, 5'b01000).
- Input 2 sends a 3-flit packet (tail on flit 3) while inputs 0 and 3 are valid -> grant_idx 2,2,2, then 3, then 0; locked=1 for exactly the two cycles after the first flit.
- Locked on input 1, out_ready=0 for 2 cycles, then owner valid drops 1 cycle -> grant_vld=0 for those 3 cycles; locked stays 1; other inputs never granted.
- ptr=3 (after a grant to input 2), only input 0 valid -> grant_idx=0, ptr becomes 1; wrap-around checked at N_REQ=4 and N_REQ=5.
- rst asserted mid-packet (locked on input 3) -> grant outputs 0 during reset; next cycle with all valid grants input 0; locked=0.
- LOCK_EN=0, input 1 sends a 3-flit packet, input 2 valid -> grants alternate 1,2,1,2,1; locked stays 0 throughout.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// -----------------------------------------------------------------------------
// noc_arb_pkg
// Shared definitions for the router output-port arbiters.
//   arb_state_e   : arbiter state encoding (IDLE / LOCKED, one-hot so that a
//                   corrupted register is detectable and recovers to IDLE)
//   DEFAULT_PLD_W : payload (route/port vector) width used by router ports
//   clog2         : ceil(log2(n)), never less than 1 so index ports exist
// -----------------------------------------------------------------------------
package noc_arb_pkg;

    localparam int DEFAULT_PLD_W = 5;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b01,
        ARB_LOCKED = 2'b10
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// -----------------------------------------------------------------------------
// rr_prio_pick
// Combinational rotating priority picker. Scans i_req starting at i_ptr,
// wrapping modulo N, and reports the first set bit.
//   i_req  [N]     : request vector
//   i_ptr  [IDX_W] : highest-priority position (must be < N)
//   o_oh   [N]     : one-hot winner (zero when nothing requested)
//   o_idx  [IDX_W] : binary winner index
//   o_any  [1]     : at least one request set
// -----------------------------------------------------------------------------
module rr_prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_oh,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    int             w_off;
    int             w_sum;

    assign w_dbl = {i_req, i_req};

    // Rotate so the pointer position lands at bit 0, take the lowest set bit,
    // then add the pointer back (mod N) to get the real input index.
    always_comb begin
        w_rot = N'(w_dbl >> i_ptr);
        w_off = 0;
        o_any = 1'b0;
        o_oh  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_any = 1'b1;
                w_off = j;
            end
        end
        w_sum = int'(i_ptr) + w_off;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        o_idx = IDX_W'(w_sum);
        for (int j = 0; j < N; j++) begin
            o_oh[j] = o_any && (o_idx == IDX_W'(j));
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// rr_packet_arbiter
// N-input round-robin arbiter for a router output port with optional
// packet locking (grant held from head flit until tail flit).
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   req_valid   [N_REQ]       : per-input request
//   req_pld     [N_REQ*PLD_W] : payloads, input i at [i*PLD_W +: PLD_W]
//   req_tail    [N_REQ]       : flit on input i ends its packet
//   out_ready   [1]           : downstream can accept this cycle
//   grant_vld   [1]           : a transfer happens this cycle
//   grant_oh    [N_REQ]       : one-hot winner
//   grant_idx   [IDX_W]       : binary winner index
//   grant_pld   [PLD_W]       : winner payload, zero when no grant
//   locked      [1]           : packet lock currently held (registered)
// -----------------------------------------------------------------------------
module rr_packet_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int PLD_W   = DEFAULT_PLD_W,
    parameter int LOCK_EN = 1,
    parameter int IDX_W   = clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*PLD_W-1:0] req_pld,
    input  logic [N_REQ-1:0]       req_tail,
    input  logic                   out_ready,
    output logic                   grant_vld,
    output logic [N_REQ-1:0]       grant_oh,
    output logic [IDX_W-1:0]       grant_idx,
    output logic [PLD_W-1:0]       grant_pld,
    output logic                   locked
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [N_REQ-1:0] w_owner_oh;
    logic [N_REQ-1:0] w_cand;
    logic [N_REQ-1:0] w_win_oh;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_any;
    logic             w_grant;
    logic             w_tail_hit;

    function automatic logic [IDX_W-1:0] nextPtr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // While locked, only the owner's request is visible to the picker, so the
    // same picker serves both states.
    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_owner_oh[i] = (r_owner == IDX_W'(i));
        end
    end

    assign w_cand = (r_state == ARB_LOCKED) ? (req_valid & w_owner_oh) : req_valid;

    rr_prio_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (w_cand),
        .i_ptr (r_ptr),
        .o_oh  (w_win_oh),
        .o_idx (w_win_idx),
        .o_any (w_any)
    );

    assign w_grant    = w_any & out_ready & ~rst;
    assign w_tail_hit = |(req_tail & w_win_oh);
    assign locked     = (r_state == ARB_LOCKED);

    // Grant outputs are zeroed whenever no transfer happens, including reset.
    always_comb begin
        grant_vld = w_grant;
        grant_oh  = '0;
        grant_idx = '0;
        grant_pld = '0;
        if (w_grant) begin
            grant_oh  = w_win_oh;
            grant_idx = w_win_idx;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_win_oh[i]) begin
                    grant_pld = grant_pld | req_pld[i*PLD_W +: PLD_W];
                end
            end
        end
    end

    // Priority only rotates when a packet completes; a head flit without tail
    // parks the arbiter on its owner instead.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant) begin
                    if (w_tail_hit || (LOCK_EN == 0)) begin
                        w_ptr_nxt = nextPtr(w_win_idx);
                    end else begin
                        w_owner_nxt = w_win_idx;
                        w_state_nxt = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (w_grant && w_tail_hit) begin
                    w_state_nxt = ARB_IDLE;
                    w_ptr_nxt   = nextPtr(r_owner);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State, pointer and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

endmodule
